spi_pwm_cmd_receiver: RTL and testbench

SPI-mode-0 slave command decoder that sits directly upstream of the 8-channel 3-bit PWM driver. It oversamples the SPI pins with the system clock, assembles 8-bit command frames and converts them into the driver's set/addr/level write strobes. It also sequences broadcast writes to all channels and echoes the previous frame on MISO for link checking.

---
 rtl/spi_pwm_cmd_receiver_if.sv | 28 ++
 rtl/spi_pwm_cmd_receiver.sv | 182 ++++++++++++++++++
 tb/tb_spi_pwm_cmd_receiver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_cmd_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pwm_cmd_receiver_if                                                  |
// | SPI pins plus PWM-driver write strobe bundle for spi_pwm_cmd_receiver.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface spi_pwm_cmd_receiver_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       set;
  logic [2:0] addr;
  logic [2:0] level;
  logic       busy;
  logic       overrun;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, set, addr, level, busy, overrun
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, set, addr, level, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/spi_pwm_cmd_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pwm_cmd_receiver                                                     |
// | Oversampled SPI mode-0 slave that decodes 8-bit commands into PWM        |
// | driver write strobes, with broadcast sequencing and MISO frame echo.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_pwm_cmd_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 8
) (
  input wire clk,
  input wire rst_n,
  spi_pwm_cmd_receiver_if.slave bus
);

  localparam logic [2:0] c_last_ch  = 3'(NUM_CH - 1);
  localparam logic [1:0] c_op_write = 2'b01;
  localparam logic [1:0] c_op_bcast = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_SEQ    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_frame;
  logic       r_frame_valid;
  logic [7:0] r_echo;
  logic [7:0] r_miso_sh;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_addr;
  logic [2:0] w_addr_nxt;
  logic [2:0] r_level;
  logic [2:0] w_level_nxt;
  logic       r_overrun;
  logic       w_drop;

  logic       w_sclk;
  logic       w_cs_n;
  logic       w_mosi;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_active;
  logic       w_cs_fall;
  logic [7:0] w_shift_in;
  logic       w_frame_done;

  assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise  = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall  = ~w_sclk & r_sclk_prev;
  assign w_cs_active  = ~w_cs_n;
  assign w_cs_fall    = r_cs_prev & ~w_cs_n;
  assign w_shift_in   = {r_shift, w_mosi};
  assign w_frame_done = w_cs_active & w_sclk_rise & (r_bit_cnt == 3'd7);

  // Chip select resets to its idle level so reset release never looks like a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_echo        <= '0;
      r_miso_sh     <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      if (!w_cs_active) begin
        r_bit_cnt <= '0;
        r_miso_sh <= '0;
      end else begin
        if (w_sclk_rise) begin
          r_shift   <= w_shift_in[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_frame_done) begin
          r_frame       <= w_shift_in;
          r_echo        <= w_shift_in;
          r_frame_valid <= 1'b1;
        end
        // A falling edge with bit_cnt==0 can only follow a completed byte.
        if (w_cs_fall || (w_sclk_fall && (r_bit_cnt == 3'd0))) begin
          r_miso_sh <= r_echo;
        end else if (w_sclk_fall) begin
          r_miso_sh <= {r_miso_sh[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_level   <= w_level_nxt;
      r_overrun <= r_overrun | w_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_level_nxt = r_level;
    w_drop      = 1'b0;
    case (r_state)
      S_SEQ: begin
        w_drop = r_frame_valid;
        if (r_addr == c_last_ch) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_nxt = r_addr + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        if (r_frame_valid) begin
          case (r_frame[7:6])
            c_op_write: begin
              w_state_nxt = S_STROBE;
              w_addr_nxt  = r_frame[5:3];
              w_level_nxt = r_frame[2:0];
            end
            c_op_bcast: begin
              w_state_nxt = S_SEQ;
              w_addr_nxt  = 3'd0;
              w_level_nxt = r_frame[2:0];
            end
            c_op_clear: begin
              w_state_nxt = S_SEQ;
              w_addr_nxt  = 3'd0;
              w_level_nxt = 3'd0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign bus.set      = (r_state != S_IDLE);
  assign bus.busy     = (r_state == S_SEQ);
  assign bus.addr     = r_addr;
  assign bus.level    = r_level;
  assign bus.overrun  = r_overrun;
  assign bus.spi_miso = r_miso_sh[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_cmd_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_pwm_cmd_receiver                                                  |
// | Table-driven bench for spi_pwm_cmd_receiver plus multi-cycle sequences. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_pwm_cmd_receiver;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_pwm_cmd_receiver_if bus();

  spi_pwm_cmd_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .NUM_CH     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] frame;
    int         n_str;
    logic [2:0] addr0;
    logic [2:0] lvl;
    int         n_busy;
    logic [7:0] echo;
  } vec_t;

  vec_t       vecs[8];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         last_rise_cyc;
  int         first_set_cyc;
  int         busy_cnt;
  int         t;
  logic [2:0] q_addr[$];
  logic [2:0] q_level[$];
  logic [7:0] miso_b;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.set) begin
      if (q_addr.size() == 0) first_set_cyc = cyc;
      q_addr.push_back(bus.addr);
      q_level.push_back(bus.level);
    end
    if (rst_n && bus.busy) busy_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    q_addr.delete();
    q_level.delete();
    busy_cnt      = 0;
    first_set_cyc = -1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int half,
                           output logic [7:0] mb);
    mb = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      repeat (half) @(negedge clk);
      mb = {mb[6:0], bus.spi_miso};
      bus.spi_sclk  = 1'b1;
      last_rise_cyc = cyc;
      repeat (half) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input int half, output logic [7:0] mb);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(b, 8, half, mb);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic wait_strobe_at(input logic [2:0] a);
    t = 0;
    while (!(bus.set && bus.busy && bus.addr == a) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("reach strobe addr %0d", a), {bus.set, bus.addr}, {1'b1, a});
  endtask

  task automatic forced_drop(input logic [2:0] at_addr);
    clear_mon();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h82, 8, 4, miso_b);
    wait_strobe_at(at_addr);
    force dut.r_frame       = 8'h4D;
    force dut.r_frame_valid = 1'b1;
    @(negedge clk);
    force dut.r_frame_valid = 1'b0;
    @(negedge clk);
    release dut.r_frame_valid;
    release dut.r_frame;
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
    check($sformatf("drop@%0d strobes", at_addr), q_addr.size(), 8);
    for (int k = 0; k < q_addr.size() && k < 8; k++) begin
      check($sformatf("drop@%0d addr[%0d]", at_addr, k), q_addr[k], k);
      check($sformatf("drop@%0d level[%0d]", at_addr, k), q_level[k], 2);
    end
    check($sformatf("drop@%0d overrun", at_addr), bus.overrun, 1);
  endtask

  initial begin
    vecs[0] = '{8'h4D, 1, 3'd1, 3'd5, 0, 8'h00};
    vecs[1] = '{8'h86, 8, 3'd0, 3'd6, 8, 8'h4D};
    vecs[2] = '{8'hC0, 8, 3'd0, 3'd0, 8, 8'h86};
    vecs[3] = '{8'h00, 0, 3'd0, 3'd0, 0, 8'hC0};
    vecs[4] = '{8'hFF, 8, 3'd0, 3'd0, 8, 8'h00};
    vecs[5] = '{8'h3F, 0, 3'd0, 3'd0, 0, 8'hFF};
    vecs[6] = '{8'h7A, 1, 3'd7, 3'd2, 0, 8'h3F};
    vecs[7] = '{8'h92, 8, 3'd0, 3'd2, 8, 8'h7A};

    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset set",     bus.set,      0);
    check("reset busy",    bus.busy,     0);
    check("reset addr",    bus.addr,     0);
    check("reset level",   bus.level,    0);
    check("reset overrun", bus.overrun,  0);
    check("reset miso",    bus.spi_miso, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      clear_mon();
      frame(vecs[v].frame, 4, miso_b);
      check($sformatf("v%0d strobes", v), q_addr.size(), vecs[v].n_str);
      for (int k = 0; k < q_addr.size() && k < vecs[v].n_str; k++) begin
        check($sformatf("v%0d addr[%0d]", v, k), q_addr[k], (vecs[v].addr0 + k) % 8);
        check($sformatf("v%0d level[%0d]", v, k), q_level[k], vecs[v].lvl);
      end
      check($sformatf("v%0d busy cycles", v), busy_cnt, vecs[v].n_busy);
      check($sformatf("v%0d miso echo", v), miso_b, vecs[v].echo);
      check($sformatf("v%0d overrun", v), bus.overrun, 0);
      if (vecs[v].n_str > 0)
        check($sformatf("v%0d latency", v), first_set_cyc - last_rise_cyc, LAT);
      if (vecs[v].n_str == 1) begin
        check($sformatf("v%0d addr hold", v), bus.addr, vecs[v].addr0);
        check($sformatf("v%0d level hold", v), bus.level, vecs[v].lvl);
      end
    end

    // Partial frame discarded by cs_n rising, then a full write.
    clear_mon();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hFF, 5, 4, miso_b);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort partial strobes", q_addr.size(), 0);
    clear_mon();
    frame(8'h4B, 4, miso_b);
    check("abort write strobes", q_addr.size(), 1);
    check("abort write addr",  q_addr.size() > 0 ? q_addr[0]  : 3'd0, 1);
    check("abort write level", q_level.size() > 0 ? q_level[0] : 3'd0, 3);
    check("abort echo", miso_b, 8'h92);

    // Two bytes streamed in one select window at sclk = clk/4.
    clear_mon();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h87, 8, 2, miso_b);
    send_bits(8'h4D, 8, 2, miso_b);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (30) @(negedge clk);
    check("stream strobes", q_addr.size(), 9);
    for (int k = 0; k < q_addr.size() && k < 8; k++) begin
      check($sformatf("stream addr[%0d]", k), q_addr[k], k);
      check($sformatf("stream level[%0d]", k), q_level[k], 7);
    end
    if (q_addr.size() > 8) begin
      check("stream write addr",  q_addr[8],  1);
      check("stream write level", q_level[8], 5);
    end
    check("stream busy cycles", busy_cnt, 8);
    check("stream overrun", bus.overrun, 0);

    // Frames landing mid-sequence and on the final strobe are dropped.
    forced_drop(3'd7);
    forced_drop(3'd2);
    clear_mon();
    frame(8'h4D, 4, miso_b);
    check("post-overrun strobes", q_addr.size(), 1);
    check("overrun sticky", bus.overrun, 1);

    // Reset in the middle of a broadcast.
    clear_mon();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h83, 8, 4, miso_b);
    wait_strobe_at(3'd3);
    rst_n = 1'b0;
    #1;
    check("midreset set",     bus.set,     0);
    check("midreset busy",    bus.busy,    0);
    check("midreset addr",    bus.addr,    0);
    check("midreset level",   bus.level,   0);
    check("midreset overrun", bus.overrun, 0);
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    check("post-reset strobes", q_addr.size(), 0);
    frame(8'h00, 4, miso_b);
    check("post-reset echo", miso_b, 8'h00);
    check("post-reset nop strobes", q_addr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
